// File: rtl/lif_spike_monitor_if.sv
// Handshake/bus bundle for lif_spike_monitor.
// master: the side that drives stimulus and consumes results.
// slave:  the monitor itself.
// rate handshake: rate_out is valid while rate_valid=1 and is consumed on
// any rising edge where rate_valid=1 and rate_ready=1.
// dbg_run exposes the FSM state (1 = RUN, 0 = IDLE) for observation.
interface lif_spike_monitor_if #(
    parameter int WINDOW_WIDTH = 8,
    parameter int ISI_WIDTH    = 8
);
    logic                    enable;
    logic                    spike_in;
    logic                    spike_valid;
    logic [WINDOW_WIDTH-1:0] window_len;
    logic                    rate_ready;
    logic                    clear_overrun;
    logic [WINDOW_WIDTH-1:0] rate_out;
    logic                    rate_valid;
    logic                    overrun;
    logic [ISI_WIDTH-1:0]    isi_out;
    logic                    isi_valid;
    logic                    dbg_run;

    modport master (
        output enable, spike_in, spike_valid, window_len, rate_ready, clear_overrun,
        input  rate_out, rate_valid, overrun, isi_out, isi_valid, dbg_run
    );

    modport slave (
        input  enable, spike_in, spike_valid, window_len, rate_ready, clear_overrun,
        output rate_out, rate_valid, overrun, isi_out, isi_valid, dbg_run
    );
endinterface

// File: rtl/lif_spike_monitor.sv
// lif_spike_monitor: counts spikes of a LIF neuron over windows of
// window_len valid samples and publishes the count through a valid/ready
// style result register with a sticky overrun flag. Optionally measures the
// inter-spike interval in samples.
// Optional feature macro: SPIKE_MONITOR_ISI_EN (ISI measurement; when it is
// undefined isi_out and isi_valid are tied to 0).
module lif_spike_monitor #(
    parameter int WINDOW_WIDTH = 8,
    parameter int ISI_WIDTH    = 8
) (
    input logic                clk,
    input logic                rst_n,
    lif_spike_monitor_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [WINDOW_WIDTH-1:0] len_q, len_d;
    logic [WINDOW_WIDTH-1:0] samp_q, samp_d;
    logic [WINDOW_WIDTH-1:0] spk_q, spk_d;
    logic [WINDOW_WIDTH-1:0] rate_out_q, rate_out_d;
    logic                    rate_valid_q, rate_valid_d;
    logic                    overrun_q, overrun_d;

    logic [WINDOW_WIDTH-1:0] samp_inc;
    logic [WINDOW_WIDTH-1:0] spk_inc;
    logic                    sample_fire;
    logic                    complete;
    logic                    start;
    logic                    overrun_set;

    // A sample only counts while running and enabled; a low enable in RUN
    // takes priority and aborts the window on that edge.
    assign sample_fire = (state_q == RUN) && bus.enable && bus.spike_valid;
    assign samp_inc    = samp_q + 1'b1;
    assign spk_inc     = spk_q + {{(WINDOW_WIDTH-1){1'b0}}, bus.spike_in};

    // Next-state logic for the window FSM, counters and result register.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        samp_d       = samp_q;
        spk_d        = spk_q;
        rate_out_d   = rate_out_q;
        rate_valid_d = rate_valid_q;
        overrun_d    = overrun_q;
        complete     = 1'b0;
        start        = 1'b0;
        overrun_set  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.enable && (bus.window_len != '0)) begin
                    state_d = RUN;
                    len_d   = bus.window_len;
                    samp_d  = '0;
                    spk_d   = '0;
                    start   = 1'b1;
                end
            end
            RUN: begin
                if (!bus.enable) begin
                    // Partial window is thrown away; result register untouched.
                    state_d = IDLE;
                    samp_d  = '0;
                    spk_d   = '0;
                end else if (bus.spike_valid) begin
                    if (samp_inc == len_q) begin
                        // Last sample of the window: it is counted, and the
                        // next window starts on the very next sample.
                        complete = 1'b1;
                        samp_d   = '0;
                        spk_d    = '0;
                        len_d    = bus.window_len;
                        if (bus.window_len == '0) begin
                            state_d = IDLE;
                        end
                    end else begin
                        samp_d = samp_inc;
                        spk_d  = spk_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A completion always loads; an accept on the same edge is absorbed
        // by the new result and is not treated as an overrun.
        if (complete) begin
            rate_out_d   = spk_inc;
            rate_valid_d = 1'b1;
            overrun_set  = rate_valid_q && !bus.rate_ready;
        end else if (rate_valid_q && bus.rate_ready) begin
            rate_valid_d = 1'b0;
        end

        // Set beats clear when both happen together.
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (bus.clear_overrun) begin
            overrun_d = 1'b0;
        end
    end

    // Window FSM and result registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            len_q        <= '0;
            samp_q       <= '0;
            spk_q        <= '0;
            rate_out_q   <= '0;
            rate_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            samp_q       <= samp_d;
            spk_q        <= spk_d;
            rate_out_q   <= rate_out_d;
            rate_valid_q <= rate_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.rate_out   = rate_out_q;
    assign bus.rate_valid = rate_valid_q;
    assign bus.overrun    = overrun_q;
    assign bus.dbg_run    = (state_q == RUN);

`ifdef SPIKE_MONITOR_ISI_EN
    logic [ISI_WIDTH-1:0] isi_cnt_q, isi_cnt_d;
    logic [ISI_WIDTH-1:0] isi_out_q, isi_out_d;
    logic                 isi_valid_q, isi_valid_d;
    logic                 seen_q, seen_d;
    logic [ISI_WIDTH-1:0] isi_inc;

    // Saturating increment: an all-ones counter means "at least max".
    assign isi_inc = (&isi_cnt_q) ? isi_cnt_q : (isi_cnt_q + 1'b1);

    // ISI next state: the interval spans windows while the block keeps
    // running; entering RUN forgets any earlier spike.
    always_comb begin
        isi_cnt_d   = isi_cnt_q;
        isi_out_d   = isi_out_q;
        isi_valid_d = 1'b0;
        seen_d      = seen_q;
        if (start) begin
            isi_cnt_d = '0;
            seen_d    = 1'b0;
        end else if (sample_fire) begin
            if (bus.spike_in) begin
                if (seen_q) begin
                    isi_out_d   = isi_inc;
                    isi_valid_d = 1'b1;
                end
                isi_cnt_d = '0;
                seen_d    = 1'b1;
            end else begin
                isi_cnt_d = isi_inc;
            end
        end
    end

    // ISI registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            isi_cnt_q   <= '0;
            isi_out_q   <= '0;
            isi_valid_q <= 1'b0;
            seen_q      <= 1'b0;
        end else begin
            isi_cnt_q   <= isi_cnt_d;
            isi_out_q   <= isi_out_d;
            isi_valid_q <= isi_valid_d;
            seen_q      <= seen_d;
        end
    end

    assign bus.isi_out   = isi_out_q;
    assign bus.isi_valid = isi_valid_q;
`else
    assign bus.isi_out   = {ISI_WIDTH{1'b0}};
    assign bus.isi_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Bench for lif_spike_monitor: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a window/sample
// level reference model.
module tb_lif_spike_monitor;

`ifdef SPIKE_MONITOR_ISI_EN
    localparam bit ISI_EN = 1'b1;
`else
    localparam bit ISI_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    lif_spike_monitor_if #(.WINDOW_WIDTH(8), .ISI_WIDTH(8)) bus ();

    lif_spike_monitor #(.WINDOW_WIDTH(8), .ISI_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Window = list of spike bits of accepted samples; ISI = distance in
    // valid-sample indices between consecutive spikes of one run.
    bit       m_run;
    int       m_len;
    int       win_q[$];
    int       m_idx;
    int       m_last;
    int       m_rate;
    bit       m_rv;
    bit       m_ov;
    int       m_isi;
    bit       m_isiv;

    task automatic model_reset();
        m_run  = 1'b0;
        m_len  = 0;
        win_q.delete();
        m_idx  = 0;
        m_last = -1;
        m_rate = 0;
        m_rv   = 1'b0;
        m_ov   = 1'b0;
        m_isi  = 0;
        m_isiv = 1'b0;
    endtask

    task automatic model_step();
        bit done;
        bit set_ov;
        bit pulse;
        int cnt;
        done   = 1'b0;
        set_ov = 1'b0;
        pulse  = 1'b0;
        cnt    = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!m_run) begin
            if (bus.enable && bus.window_len != 0) begin
                m_run  = 1'b1;
                m_len  = int'(bus.window_len);
                win_q.delete();
                m_idx  = 0;
                m_last = -1;
            end
        end else if (!bus.enable) begin
            m_run = 1'b0;
        end else if (bus.spike_valid) begin
            win_q.push_back(int'(bus.spike_in));
            m_idx++;
            if (bus.spike_in) begin
                if (m_last >= 0) begin
                    m_isi = (m_idx - m_last > 255) ? 255 : (m_idx - m_last);
                    pulse = 1'b1;
                end
                m_last = m_idx;
            end
            if (win_q.size() == m_len) begin
                done = 1'b1;
                foreach (win_q[i]) cnt += win_q[i];
                win_q.delete();
                if (bus.window_len == 0) m_run = 1'b0;
                else m_len = int'(bus.window_len);
            end
        end
        if (done) begin
            if (m_rv && !bus.rate_ready) set_ov = 1'b1;
            m_rate = cnt;
            m_rv   = 1'b1;
        end else if (m_rv && bus.rate_ready) begin
            m_rv = 1'b0;
        end
        if (set_ov) m_ov = 1'b1;
        else if (bus.clear_overrun) m_ov = 1'b0;
        m_isiv = pulse;
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("rate_out", 32'(bus.rate_out), 32'(m_rate));
        chk("rate_valid", 32'(bus.rate_valid), 32'(m_rv));
        chk("overrun", 32'(bus.overrun), 32'(m_ov));
        chk("dbg_run", 32'(bus.dbg_run), 32'(m_run));
        chk("isi_out", 32'(bus.isi_out), ISI_EN ? 32'(m_isi) : 32'd0);
        chk("isi_valid", 32'(bus.isi_valid), ISI_EN ? 32'(m_isiv) : 32'd0);
    endtask

    // One clock: inputs already applied; model follows the same edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit en, input bit sp, input bit sv,
                         input logic [7:0] wl, input bit rr, input bit co);
        bus.enable        = en;
        bus.spike_in      = sp;
        bus.spike_valid   = sv;
        bus.window_len    = wl;
        bus.rate_ready    = rr;
        bus.clear_overrun = co;
        tick();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         rst_n;
        bit         en;
        bit         sp;
        bit         sv;
        logic [7:0] wl;
        bit         rr;
        bit         co;
        logic [7:0] e_rate;
        bit         e_rv;
        bit         e_ov;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input bit r, input bit en, input bit sp, input bit sv,
                           input logic [7:0] wl, input bit rr, input bit co,
                           input logic [7:0] e_rate, input bit e_rv, input bit e_ov);
        vec_t v;
        v.rst_n = r; v.en = en; v.sp = sp; v.sv = sv; v.wl = wl;
        v.rr = rr; v.co = co; v.e_rate = e_rate; v.e_rv = e_rv; v.e_ov = e_ov;
        vq.push_back(v);
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.enable        = 1'b0;
        bus.spike_in      = 1'b0;
        bus.spike_valid   = 1'b0;
        bus.window_len    = 8'd0;
        bus.rate_ready    = 1'b0;
        bus.clear_overrun = 1'b0;
        model_reset();

        // rst en sp sv wl rr co | rate rv ov
        add_vec(0, 0, 0, 0, 4, 1, 0, 0, 0, 0);  // reset state
        add_vec(1, 1, 0, 0, 4, 1, 0, 0, 0, 0);  // IDLE->RUN, len 4
        add_vec(1, 1, 1, 1, 4, 1, 0, 0, 0, 0);  // s1 spike
        add_vec(1, 1, 0, 1, 4, 1, 0, 0, 0, 0);  // s2
        add_vec(1, 1, 1, 1, 4, 1, 0, 0, 0, 0);  // s3 spike
        add_vec(1, 1, 0, 1, 4, 1, 0, 2, 1, 0);  // s4 completes -> 2
        add_vec(1, 1, 0, 0, 4, 1, 0, 2, 0, 0);  // accepted, valid one cycle
        add_vec(1, 0, 0, 0, 3, 0, 0, 2, 0, 0);  // back to IDLE
        add_vec(1, 1, 0, 0, 3, 0, 0, 2, 0, 0);  // RUN, len 3, no ready
        add_vec(1, 1, 1, 1, 3, 0, 0, 2, 0, 0);
        add_vec(1, 1, 0, 1, 3, 0, 0, 2, 0, 0);
        add_vec(1, 1, 0, 1, 3, 0, 0, 1, 1, 0);  // window 1 -> 1
        add_vec(1, 1, 1, 1, 3, 0, 0, 1, 1, 0);
        add_vec(1, 1, 1, 1, 3, 0, 0, 1, 1, 0);
        add_vec(1, 1, 1, 1, 3, 0, 1, 3, 1, 1);  // overwrite; set beats clear
        add_vec(1, 0, 0, 0, 3, 0, 1, 3, 1, 0);  // clear pulse
        add_vec(1, 0, 0, 0, 3, 1, 0, 3, 0, 0);  // accept

        repeat (2) @(negedge clk);
        foreach (vq[i]) begin
            rst_n = vq[i].rst_n;
            drive(vq[i].en, vq[i].sp, vq[i].sv, vq[i].wl, vq[i].rr, vq[i].co);
            chk($sformatf("vec%0d_rate_out", i), 32'(bus.rate_out), 32'(vq[i].e_rate));
            chk($sformatf("vec%0d_rate_valid", i), 32'(bus.rate_valid), 32'(vq[i].e_rv));
            chk($sformatf("vec%0d_overrun", i), 32'(bus.overrun), 32'(vq[i].e_ov));
        end

        // Accept on the same edge as the next completion.
        drive(1, 0, 0, 2, 0, 0);
        drive(1, 1, 1, 2, 0, 0);
        drive(1, 1, 1, 2, 0, 0);
        chk("pend_rate_out", 32'(bus.rate_out), 32'd2);
        drive(1, 1, 1, 2, 0, 0);
        drive(1, 0, 1, 2, 1, 0);
        chk("same_edge_rate_out", 32'(bus.rate_out), 32'd1);
        chk("same_edge_rate_valid", 32'(bus.rate_valid), 32'd1);
        chk("same_edge_overrun", 32'(bus.overrun), 32'd0);
        drive(1, 0, 0, 2, 1, 0);
        chk("after_accept_valid", 32'(bus.rate_valid), 32'd0);

        // spike_in without spike_valid is ignored.
        repeat (10) drive(1, 1, 0, 2, 1, 0);
        chk("novalid_rate_valid", 32'(bus.rate_valid), 32'd0);
        chk("novalid_rate_out", 32'(bus.rate_out), 32'd1);
        drive(1, 0, 1, 2, 1, 0);
        chk("novalid_one_sample", 32'(bus.rate_valid), 32'd0);
        drive(1, 0, 1, 2, 1, 0);
        chk("novalid_count", 32'(bus.rate_out), 32'd0);
        chk("novalid_done", 32'(bus.rate_valid), 32'd1);

        // Enable dropped mid-window.
        drive(0, 0, 0, 4, 1, 0);
        drive(1, 0, 0, 4, 1, 0);
        drive(1, 1, 1, 4, 1, 0);
        drive(1, 1, 1, 4, 1, 0);
        drive(0, 0, 1, 4, 1, 0);
        chk("abort_rate_valid", 32'(bus.rate_valid), 32'd0);
        drive(1, 0, 0, 4, 1, 0);
        drive(1, 0, 1, 4, 1, 0);
        drive(1, 0, 1, 4, 1, 0);
        drive(1, 0, 1, 4, 1, 0);
        drive(1, 1, 1, 4, 1, 0);
        chk("abort_fresh_count", 32'(bus.rate_out), 32'd1);
        chk("abort_fresh_valid", 32'(bus.rate_valid), 32'd1);
        chk("abort_first_isi", 32'(bus.isi_valid), 32'd0);

        // Reset mid-window.
        drive(1, 1, 1, 4, 1, 0);
        drive(1, 1, 1, 4, 1, 0);
        rst_n = 1'b0;
        drive(1, 1, 1, 4, 1, 0);
        chk("rst_rate_out", 32'(bus.rate_out), 32'd0);
        chk("rst_rate_valid", 32'(bus.rate_valid), 32'd0);
        chk("rst_isi_out", 32'(bus.isi_out), 32'd0);
        rst_n = 1'b1;
        drive(1, 0, 0, 4, 1, 0);
        drive(1, 1, 1, 4, 1, 0);
        chk("rst_first_isi", 32'(bus.isi_valid), 32'd0);
        drive(1, 0, 1, 4, 1, 0);
        drive(1, 0, 1, 4, 1, 0);
        drive(1, 0, 1, 4, 1, 0);
        chk("rst_fresh_count", 32'(bus.rate_out), 32'd1);

        // Inter-spike interval: spikes at samples 2 and 7, then 300 later.
        drive(0, 0, 0, 8, 1, 0);
        drive(1, 0, 0, 8, 1, 0);
        drive(1, 0, 1, 8, 1, 0);
        drive(1, 1, 1, 8, 1, 0);
        chk("isi_first_spike", 32'(bus.isi_valid), 32'd0);
        repeat (4) drive(1, 0, 1, 8, 1, 0);
        drive(1, 1, 1, 8, 1, 0);
        chk("isi_five_valid", 32'(bus.isi_valid), ISI_EN ? 32'd1 : 32'd0);
        chk("isi_five_value", 32'(bus.isi_out), ISI_EN ? 32'd5 : 32'd0);
        repeat (299) drive(1, 0, 1, 8, 1, 0);
        chk("isi_pulse_single", 32'(bus.isi_valid), 32'd0);
        drive(1, 1, 1, 8, 1, 0);
        chk("isi_sat_valid", 32'(bus.isi_valid), ISI_EN ? 32'd1 : 32'd0);
        chk("isi_sat_value", 32'(bus.isi_out), ISI_EN ? 32'd255 : 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] wl;
            wl    = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            rst_n = ($urandom_range(0, 199) != 0);
            drive($urandom_range(0, 19) != 0, $urandom_range(0, 9) < 4,
                  $urandom_range(0, 9) < 6, wl, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) == 0);
        end
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lif_spike_monitor.md
LIF_SPIKE_MONITOR -- requirements
Module: lif_spike_monitor

Interface
REQ-001 Parameter WINDOW_WIDTH, default 8: width of window length, sample counter and rate_out.
REQ-002 Parameter ISI_WIDTH, default 8: width of the inter-spike-interval counter and isi_out.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1: reset, synchronous, active-low.
REQ-005 Port enable  input  1: high runs measurement windows; low idles the block.
REQ-006 Port spike_in  input  1: neuron spike output for the current sample.
REQ-007 Port spike_valid  input  1: high on each cycle the neuron commits a new membrane update (one sample).
REQ-008 Port window_len  input  WINDOW_WIDTH: samples per window; 0 is not a valid length.
REQ-009 Port rate_ready  input  1: consumer accepts rate_out.
REQ-010 Port clear_overrun  input  1: clears the overrun flag.
REQ-011 Port rate_out  output  WINDOW_WIDTH: spike count of the last completed window.
REQ-012 Port rate_valid  output  1: rate_out holds an unconsumed result.
REQ-013 Port overrun  output  1: sticky; a completed result was overwritten before acceptance.
REQ-014 Port isi_out  output  ISI_WIDTH: last inter-spike interval, in samples.
REQ-015 Port isi_valid  output  1: one-cycle pulse when isi_out is updated.

Function
REQ-016 The FSM SHALL have two states: IDLE and RUN.
REQ-017 IDLE->RUN at a clock edge where enable=1 and window_len!=0; window_len is latched as the active length, sample and spike counters cleared.
REQ-018 RUN->IDLE at any edge where enable=0; the partial window is discarded, rate_out/rate_valid/overrun unchanged.
REQ-019 In RUN, each spike_valid=1 cycle increments the sample counter, and also the spike counter if spike_in=1; spike_in is ignored when spike_valid=0.
REQ-020 The window completes on the edge consuming the sample that makes the sample count equal the latched length; a spike on that sample counts in that window.
REQ-021 On completion rate_out SHALL load the spike count and rate_valid SHALL be 1 from the next cycle (1-cycle latency); the next window starts immediately with no lost sample, re-latching window_len (changes mid-window take effect at the next window only).
REQ-022 If window_len=0 at completion, the block SHALL return to IDLE after publishing the result.
REQ-023 rate_valid SHALL clear on an edge where rate_valid=1 and rate_ready=1, unless a window completes on the same edge, in which case the new result loads, rate_valid stays 1 and overrun is not set.
REQ-024 A completion with rate_valid=1 and rate_ready=0 SHALL overwrite rate_out and set overrun.
REQ-025 overrun SHALL clear on clear_overrun=1; if set and clear coincide, set wins.
REQ-026 ISI counter (RUN only): increments, saturating at 2^ISI_WIDTH-1, on each valid non-spike sample; on a valid spike sample, if a previous spike exists, isi_out loads min(counter+1, max) and isi_valid pulses next cycle; counter then clears.
REQ-027 The first spike after reset or after IDLE->RUN SHALL NOT produce isi_valid.

Reset
REQ-028 With rst_n=0 at an edge: state=IDLE, all counters 0, rate_out=0, rate_valid=0, overrun=0, isi_out=0, isi_valid=0; reset overrides all other inputs, including mid-window.

Configuration
REQ-029 Macro SPIKE_MONITOR_ISI_EN: when defined, REQ-026/027 are implemented; when undefined, no ISI logic exists, isi_out is constant 0 and isi_valid is constant 0; rate behaviour is identical in both builds.

Verification
REQ-030 window_len=4, rate_ready=1, spikes on samples 1 and 3 -> rate_out=2, rate_valid=1 for exactly one cycle after the 4th sample's edge.
REQ-031 window_len=3, rate_ready=0, two full windows with counts 1 then 3 -> rate_out=3, overrun=1; then clear_overrun pulse -> overrun=0.
REQ-032 Result pending, rate_ready=1 on the same edge as the next completion -> rate_valid stays 1, new count shown, overrun=0.
REQ-033 ISI build: valid-sample spikes at samples 2, 7, then a gap of 300 samples -> isi_out=5 with isi_valid pulse, then isi_out=255; no pulse for the sample-2 spike.
REQ-034 enable dropped mid-window, or rst_n=0 mid-window -> no result published; after re-enable the next window counts from 0 and the first spike gives no isi_valid.
REQ-035 spike_in=1 with spike_valid=0 for 10 cycles -> no counter change, no completion.
